// File: rtl/i2c_txn_sequencer.sv
// ============================================================================
// Module   : i2c_txn_sequencer
// Purpose  : Queues host I2C commands and runs them one at a time on a byte
//            master, returning a status/read-data response per command.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_txn_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                        clk_400,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rw,
  input  logic [6:0]                  cmd_addr,
  input  logic [7:0]                  cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [7:0]                  rsp_rdata,
  output logic [1:0]                  rsp_status,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        m_start_txn,
  output logic                        m_rw,
  output logic                        m_data_valid,
  output logic                        m_next_byte,
  output logic [6:0]                  m_sub_addr,
  output logic [7:0]                  m_data_in,
  input  logic                        m_busy,
  input  logic                        m_done,
  input  logic                        m_ack_error,
  input  logic                        m_data_ready,
  input  logic [7:0]                  m_data_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TIMEOUT_CYC) + 1;

  localparam logic [1:0]    c_idle      = 2'd0;
  localparam logic [1:0]    c_launch    = 2'd1;
  localparam logic [1:0]    c_wait_done = 2'd2;
  localparam logic [1:0]    c_resp      = 2'd3;
  localparam logic [1:0]    c_st_ok     = 2'b00;
  localparam logic [1:0]    c_st_nack   = 2'b01;
  localparam logic [1:0]    c_st_tmo    = 2'b10;
  localparam logic [LW-1:0] c_depth     = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] c_tmo_last  = CW'(TIMEOUT_CYC - 1);

  logic [15:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [CW-1:0] r_count;
  logic [15:0]   r_cmd;
  logic          r_nack;
  logic [7:0]    r_rdata;
  logic [1:0]    r_rsp_status;
  logic [7:0]    r_rsp_rdata;
  logic [1:0]    r_state, w_next_state;

  logic       w_full, w_push, w_pop, w_done, w_timeout, w_nack_now;
  logic [1:0] w_status;
  logic [7:0] w_final_rdata;

  assign w_full     = (r_level == c_depth);
  assign cmd_ready  = !w_full;
  assign w_push     = cmd_valid && !w_full;
  assign w_pop      = (r_state == c_idle) && (r_level != '0) && !m_busy;
  assign w_done     = (r_state == c_wait_done) && m_done;
  assign w_timeout  = (r_state == c_wait_done) && (r_count == c_tmo_last) && !m_done;
  assign w_nack_now = r_nack || m_ack_error;
  assign w_status   = w_done ? (w_nack_now ? c_st_nack : c_st_ok) : c_st_tmo;
  // Same-cycle data_ready/ack_error with m_done still count toward the response.
  assign w_final_rdata = (w_done && !w_nack_now && r_cmd[15]) ?
                         (m_data_ready ? m_data_out : r_rdata) : 8'h00;
  assign fifo_level  = r_level;
  assign m_next_byte = 1'b0;

  always_ff @(posedge clk_400) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk_400) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_count      <= '0;
      r_cmd        <= '0;
      r_nack       <= 1'b0;
      r_rdata      <= '0;
      r_rsp_status <= '0;
      r_rsp_rdata  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_pop) begin
        r_cmd    <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count  <= '0;
        r_nack   <= 1'b0;
        r_rdata  <= '0;
      end
      if (r_state == c_wait_done) begin
        r_count <= r_count + 1'b1;
        if (m_ack_error) begin
          r_nack <= 1'b1;
        end
        if (m_data_ready) begin
          r_rdata <= m_data_out;
        end
      end
      if (w_done || w_timeout) begin
        r_rsp_status <= w_status;
        r_rsp_rdata  <= w_final_rdata;
      end
    end
  end

  always_ff @(posedge clk_400) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle:      if (w_pop) w_next_state = c_launch;
      c_launch:    w_next_state = c_wait_done;
      c_wait_done: if (w_done || w_timeout) w_next_state = c_resp;
      c_resp:      if (rsp_ready) w_next_state = c_idle;
      default:     w_next_state = c_idle;
    endcase
  end

  always_comb begin
    m_start_txn  = 1'b0;
    m_rw         = 1'b0;
    m_sub_addr   = '0;
    m_data_in    = '0;
    m_data_valid = 1'b0;
    rsp_valid    = 1'b0;
    rsp_rdata    = '0;
    rsp_status   = '0;
    if (r_state == c_launch) begin
      m_start_txn = 1'b1;
    end
    if ((r_state == c_launch) || (r_state == c_wait_done)) begin
      m_rw         = r_cmd[15];
      m_sub_addr   = r_cmd[14:8];
      m_data_in    = r_cmd[7:0];
      m_data_valid = !r_cmd[15];
    end
    if (r_state == c_resp) begin
      rsp_valid  = 1'b1;
      rsp_rdata  = r_rsp_rdata;
      rsp_status = r_rsp_status;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_txn_sequencer.sv
// ============================================================================
// Module   : tb_i2c_txn_sequencer
// Purpose  : Scoreboard bench for i2c_txn_sequencer with a scripted master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_txn_sequencer;

  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 16;

  logic       clk_400 = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready, cmd_rw;
  logic [6:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_status;
  logic [2:0] fifo_level;
  logic       m_start_txn, m_rw, m_data_valid, m_next_byte;
  logic [6:0] m_sub_addr;
  logic [7:0] m_data_in;
  logic       m_busy, m_done, m_ack_error, m_data_ready;
  logic [7:0] m_data_out;

  i2c_txn_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_400(clk_400), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_status(rsp_status), .fifo_level(fifo_level),
    .m_start_txn(m_start_txn), .m_rw(m_rw), .m_data_valid(m_data_valid),
    .m_next_byte(m_next_byte), .m_sub_addr(m_sub_addr), .m_data_in(m_data_in),
    .m_busy(m_busy), .m_done(m_done), .m_ack_error(m_ack_error),
    .m_data_ready(m_data_ready), .m_data_out(m_data_out)
  );

  always #5 clk_400 = ~clk_400;

  typedef struct { logic rw; logic [6:0] addr; logic [7:0] wdata; } launch_t;
  typedef struct { logic [1:0] status; logic [7:0] rdata; int lat; } rsp_t;
  typedef struct { int delay; bit nack; bit rdy; logic [7:0] rd; bit hang; } beh_t;

  launch_t exp_launch[$];
  rsp_t    exp_rsp[$];
  beh_t    beh_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_launch_cyc = 0;

  always @(posedge clk_400) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Launch monitor: every start pulse must match the next queued command.
  always @(negedge clk_400) begin
    if (m_start_txn) begin
      launch_t e;
      if (exp_launch.size() == 0) begin
        fail_now("unexpected_launch");
      end else begin
        e = exp_launch.pop_front();
        chk("launch_rw", m_rw, e.rw);
        chk("launch_addr", m_sub_addr, e.addr);
        if (!e.rw) chk("launch_wdata", m_data_in, e.wdata);
        chk("launch_data_valid", m_data_valid, !e.rw);
        chk("launch_next_byte", m_next_byte, 1'b0);
      end
      last_launch_cyc = cyc;
    end
  end

  // Response monitor: pops the scoreboard on each accepted response.
  always @(negedge clk_400) begin
    if (rsp_valid && rsp_ready) begin
      rsp_t e;
      if (exp_rsp.size() == 0) begin
        fail_now("unexpected_response");
      end else begin
        e = exp_rsp.pop_front();
        chk("rsp_status", rsp_status, e.status);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        if (e.lat >= 0) chk("rsp_latency", cyc - last_launch_cyc, e.lat);
      end
    end
  end

  // Scripted master: plays one behaviour per start pulse.
  initial begin
    beh_t b;
    forever begin
      @(negedge clk_400);
      if (m_start_txn) begin
        if (beh_q.size() == 0) begin
          fail_now("master_no_behaviour");
        end else begin
          b = beh_q.pop_front();
          repeat (b.delay + 1) @(posedge clk_400);
          #1;
          if (b.rdy) begin
            m_data_out = b.rd;
            m_data_ready = 1'b1;
            @(posedge clk_400); #1;
            m_data_ready = 1'b0;
          end
          if (b.nack) begin
            m_ack_error = 1'b1;
            @(posedge clk_400); #1;
            m_ack_error = 1'b0;
          end
          if (!b.hang) begin
            m_done = 1'b1;
            @(posedge clk_400); #1;
            m_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic push_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                          input beh_t b, input rsp_t r);
    launch_t l;
    int n = 0;
    bit acc = 0;
    l.rw = rw; l.addr = addr; l.wdata = wdata;
    exp_launch.push_back(l);
    exp_rsp.push_back(r);
    beh_q.push_back(b);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = addr; cmd_wdata = wdata;
    while (!acc && n < 200) begin
      @(negedge clk_400);
      acc = cmd_ready;
      @(posedge clk_400); #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!acc) fail_now("push_accept_timeout");
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_launch.size() != 0 || fifo_level != 0) && n < 400) begin
      @(negedge clk_400);
      n++;
    end
    if (n >= 400) fail_now("drain_timeout");
    @(posedge clk_400); #1;
  endtask

  function automatic beh_t mk_beh(input int d, input bit nk, input bit rdy,
                                  input logic [7:0] rd, input bit hang);
    beh_t b;
    b.delay = d; b.nack = nk; b.rdy = rdy; b.rd = rd; b.hang = hang;
    return b;
  endfunction

  function automatic rsp_t mk_rsp(input logic [1:0] st, input logic [7:0] rd, input int lat);
    rsp_t r;
    r.status = st; r.rdata = rd; r.lat = lat;
    return r;
  endfunction

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_ack_error = 1'b0;
    m_data_ready = 1'b0; m_data_out = '0;
    repeat (3) @(posedge clk_400);
    #1 rst_n = 1'b1;
    @(negedge clk_400);
    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_level", fifo_level, 3'd0);
    chk("reset_start", m_start_txn, 1'b0);
    chk("reset_data_valid", m_data_valid, 1'b0);
    @(posedge clk_400); #1;

    // Simple write
    push_cmd(1'b0, 7'h50, 8'hA5, mk_beh(2, 0, 0, 8'h00, 0), mk_rsp(2'b00, 8'h00, -1));
    drain();

    // Read with response held back, second command must not launch meanwhile
    rsp_ready = 1'b0;
    push_cmd(1'b1, 7'h68, 8'h00, mk_beh(1, 0, 1, 8'h3C, 0), mk_rsp(2'b00, 8'h3C, -1));
    push_cmd(1'b0, 7'h11, 8'h22, mk_beh(0, 0, 0, 8'h00, 0), mk_rsp(2'b00, 8'h00, -1));
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk_400); n++; end
    if (n >= 100) fail_now("read_rsp_wait_timeout");
    repeat (4) begin
      @(negedge clk_400);
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_rdata", rsp_rdata, 8'h3C);
      chk("hold_no_start", m_start_txn, 1'b0);
    end
    @(posedge clk_400); #1 rsp_ready = 1'b1;
    drain();

    // NACKed write
    push_cmd(1'b0, 7'h2A, 8'h5A, mk_beh(1, 1, 0, 8'h00, 0), mk_rsp(2'b01, 8'h00, -1));
    drain();
    @(negedge clk_400);
    chk("nack_back_idle_rsp", rsp_valid, 1'b0);
    chk("nack_back_idle_start", m_start_txn, 1'b0);
    @(posedge clk_400); #1;

    // Timeout on a read that saw data but no done, then the queued command runs
    push_cmd(1'b1, 7'h33, 8'h00, mk_beh(0, 0, 1, 8'hEE, 1), mk_rsp(2'b10, 8'h00, TIMEOUT_CYC + 1));
    push_cmd(1'b1, 7'h34, 8'h00, mk_beh(2, 0, 1, 8'h99, 0), mk_rsp(2'b00, 8'h99, -1));
    drain();

    // Fill while master busy; a fifth push must be refused
    m_busy = 1'b1;
    push_cmd(1'b0, 7'h10, 8'h01, mk_beh(0, 0, 0, 8'h00, 0), mk_rsp(2'b00, 8'h00, -1));
    push_cmd(1'b1, 7'h11, 8'h00, mk_beh(1, 0, 1, 8'hB2, 0), mk_rsp(2'b00, 8'hB2, -1));
    push_cmd(1'b0, 7'h12, 8'h03, mk_beh(0, 1, 0, 8'h00, 0), mk_rsp(2'b01, 8'h00, -1));
    push_cmd(1'b1, 7'h13, 8'h00, mk_beh(0, 1, 1, 8'h77, 0), mk_rsp(2'b01, 8'h00, -1));
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h7F; cmd_wdata = 8'hFF;
    repeat (3) begin
      @(negedge clk_400);
      chk("full_level", fifo_level, 3'd4);
      chk("full_cmd_ready", cmd_ready, 1'b0);
    end
    @(posedge clk_400); #1 cmd_valid = 1'b0;
    m_busy = 1'b0;
    push_cmd(1'b0, 7'h14, 8'h05, mk_beh(0, 0, 0, 8'h00, 0), mk_rsp(2'b00, 8'h00, -1));
    drain();
    @(negedge clk_400);
    chk("drained_level", fifo_level, 3'd0);
    @(posedge clk_400); #1;

    // Reset in the middle of a transaction with three commands queued
    push_cmd(1'b0, 7'h70, 8'h01, mk_beh(0, 0, 0, 8'h00, 1), mk_rsp(2'b10, 8'h00, -1));
    push_cmd(1'b0, 7'h71, 8'h02, mk_beh(0, 0, 0, 8'h00, 0), mk_rsp(2'b00, 8'h00, -1));
    push_cmd(1'b0, 7'h72, 8'h03, mk_beh(0, 0, 0, 8'h00, 0), mk_rsp(2'b00, 8'h00, -1));
    push_cmd(1'b0, 7'h73, 8'h04, mk_beh(0, 0, 0, 8'h00, 0), mk_rsp(2'b00, 8'h00, -1));
    repeat (2) @(negedge clk_400);
    chk("pre_reset_level", fifo_level, 3'd3);
    @(posedge clk_400); #1 rst_n = 1'b0;
    exp_launch.delete(); exp_rsp.delete(); beh_q.delete();
    repeat (2) @(posedge clk_400);
    #1 rst_n = 1'b1;
    @(negedge clk_400);
    chk("post_reset_level", fifo_level, 3'd0);
    chk("post_reset_rsp_valid", rsp_valid, 1'b0);
    chk("post_reset_cmd_ready", cmd_ready, 1'b1);
    repeat (8) begin
      @(negedge clk_400);
      chk("post_reset_no_start", m_start_txn, 1'b0);
    end
    @(posedge clk_400); #1;
    push_cmd(1'b0, 7'h0F, 8'hF0, mk_beh(1, 0, 0, 8'h00, 0), mk_rsp(2'b00, 8'h00, -1));
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule

`default_nettype wire

// File: doc/i2c_txn_sequencer.md
I2C_TXN_SEQUENCER -- requirements
Module: i2c_txn_sequencer

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4, meaning command FIFO entries (power of 2, at least 2).
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 1024, meaning the clk_400 cycles allowed from launch to m_done.
REQ-003 clk_400  in  1  400 kHz system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 cmd_valid  in  1  host command valid.
REQ-006 cmd_ready  out  1  FIFO can accept a command.
REQ-007 cmd_rw  in  1  0 = write, 1 = read.
REQ-008 cmd_addr  in  7  target address.
REQ-009 cmd_wdata  in  8  write byte (ignored for reads).
REQ-010 rsp_valid  out  1  response valid.
REQ-011 rsp_ready  in  1  host accepts response.
REQ-012 rsp_rdata  out  8  read byte; 0 for writes and failures.
REQ-013 rsp_status  out  2  00 = OK, 01 = NACK, 10 = TIMEOUT.
REQ-014 fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.
REQ-015 m_start_txn, m_rw, m_data_valid, m_next_byte  out  1 each  master controls.
REQ-016 m_sub_addr  out  7 and m_data_in  out  8  master address and data.
REQ-017 m_busy, m_done, m_ack_error, m_data_ready  in  1 each and m_data_out  in  8  master status and read data.

Function
REQ-018 Command push SHALL occur on cmd_valid && cmd_ready, storing {rw, addr, wdata} (16 bits) at the write pointer.
REQ-019 cmd_ready SHALL equal !full from registered state; a push when full SHALL NOT be accepted, even if a pop occurs in the same cycle.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL be exact on simultaneous push and pop (unchanged).
REQ-021 A command pushed into an empty FIFO SHALL become poppable no earlier than the next cycle.
REQ-022 FSM states SHALL be IDLE, LAUNCH, WAIT_DONE and RESP.
REQ-023 IDLE to LAUNCH when FIFO not empty and m_busy = 0; pop the head into the command register that cycle.
REQ-024 In LAUNCH: m_start_txn = 1 for exactly one cycle; m_rw, m_sub_addr and m_data_in driven from the command register; m_data_valid = !rw; then go to WAIT_DONE.
REQ-025 m_rw, m_sub_addr and m_data_in SHALL stay stable from LAUNCH until leaving WAIT_DONE; m_data_valid SHALL stay 1 for writes during that span; m_next_byte SHALL be 0 at all times.
REQ-026 WAIT_DONE SHALL OR m_ack_error into a sticky nack flag and capture m_data_out into rdata on m_data_ready.
REQ-027 WAIT_DONE SHALL count cycles from 0; on m_done go to RESP with status 01 if nack else 00.
REQ-028 If count reaches TIMEOUT_CYC-1 without m_done, go to RESP with status 10 and rdata 0.
REQ-029 m_done and the timeout in the same cycle SHALL resolve to m_done.
REQ-030 RESP SHALL hold rsp_valid = 1 with stable rsp_rdata and rsp_status until rsp_ready, then go to IDLE; no new launch while in RESP.
REQ-031 rsp_rdata SHALL be the captured byte only for status 00 with rw = 1, else 0.
REQ-032 Host pushes SHALL remain legal in every FSM state.

Reset
REQ-033 On rst_n = 0: FSM to IDLE; pointers, fifo_level, counter, nack and rdata cleared; cmd_ready = 1; all other outputs 0.
REQ-034 Reset mid-transaction SHALL flush the FIFO and drop the pending response, with no m_start_txn pulse in the first cycle after release.

Verification
REQ-035 Write 0x50/0xA5, master done with no ack_error -> one start pulse with m_rw = 0, m_sub_addr = 0x50, m_data_in = 0xA5; response status 00, rdata 0x00.
REQ-036 Read 0x68, master returns 0x3C with m_data_ready then m_done -> response status 00, rdata 0x3C.
REQ-037 Write with m_ack_error pulsed before m_done -> status 01, rdata 0x00, FSM back to IDLE.
REQ-038 m_done never asserted -> status 10 exactly TIMEOUT_CYC cycles after LAUNCH+1; next queued command then launches.
REQ-039 Push 5 commands back-to-back with DEPTH = 4 while the master is busy -> cmd_ready low at level 4; all accepted commands complete in FIFO order; level reaches 0.
REQ-040 Assert rst_n = 0 during WAIT_DONE with 3 commands queued -> level 0, rsp_valid 0, no start pulse until a new push.
